// File: rtl/alu_arbiter_pkg.sv
// Shared definitions for the ALU arbiter slice.
//   - ALU op-code constants understood by alu32
//   - arbiter FSM state encoding
//   - is_legal_op(): true for op codes alu32 implements
package alu_arbiter_pkg;

  localparam logic [2:0] ALU_AND = 3'b000;
  localparam logic [2:0] ALU_OR  = 3'b001;
  localparam logic [2:0] ALU_ADD = 3'b010;
  localparam logic [2:0] ALU_SLL = 3'b101;
  localparam logic [2:0] ALU_SUB = 3'b110;
  localparam logic [2:0] ALU_SLT = 3'b111;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    DONE = 2'd2
  } state_t;

  function automatic logic is_legal_op(input logic [2:0] op);
    logic ok;
    case (op)
      ALU_AND, ALU_OR, ALU_ADD, ALU_SLL, ALU_SUB, ALU_SLT: ok = 1'b1;
      default:                                             ok = 1'b0;
    endcase
    return ok;
  endfunction

endpackage

// File: rtl/alu_arbiter_alu32.sv
// Purpose: 32-bit combinational ALU shared by the arbiter's requesters.
// Ports:
//   a, b  : operands
//   f     : op code (see alu_arbiter_pkg constants)
//   y     : result (0 for op codes it does not implement)
//   zero  : y == 0
module alu32
  import alu_arbiter_pkg::*;
(
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic [2:0]  f,
  output logic [31:0] y,
  output logic        zero
);

  logic signed [31:0] sa;
  logic signed [31:0] sb;

  assign sa = a;
  assign sb = b;

  always_comb begin
    y = '0;
    case (f)
      ALU_ADD: y = a + b;
      ALU_SUB: y = a - b;
      ALU_SLT: y = {31'b0, (sa < sb)};
      ALU_AND: y = a & b;
      ALU_OR:  y = a | b;
      // Whole 32-bit b is the shift amount; anything >= 32 shifts every bit out.
      ALU_SLL: y = (|b[31:5]) ? '0 : (a << b[4:0]);
      default: y = '0;
    endcase
  end

  assign zero = (y == '0);

endmodule

// File: rtl/alu_arbiter.sv
// Purpose: time-multiplexes one alu32 between two requesters with a
// round-robin req/gnt handshake. An op accepted in cycle N is executed from
// latched operands in N+1 and its registered result is presented with a
// one-cycle rvalid pulse in N+2. A new op may be granted in that same cycle,
// giving one op every two cycles.
// Ports:
//   clk, reset                 : clock, synchronous active-high reset
//   rX_req, rX_a, rX_b, rX_op  : request and operands from requester X
//   rX_gnt                     : combinational accept for requester X
//   rX_rvalid                  : one-cycle response pulse for requester X
//   rX_result, rX_zero, rX_err : response data, held until the next rX_rvalid
module alu_arbiter
  import alu_arbiter_pkg::*;
#(
  parameter int DATA_W    = 32,
  parameter int PRIO_INIT = 0
) (
  input  logic              clk,
  input  logic              reset,

  input  logic              r0_req,
  input  logic [DATA_W-1:0] r0_a,
  input  logic [DATA_W-1:0] r0_b,
  input  logic [2:0]        r0_op,
  output logic              r0_gnt,
  output logic              r0_rvalid,
  output logic [DATA_W-1:0] r0_result,
  output logic              r0_zero,
  output logic              r0_err,

  input  logic              r1_req,
  input  logic [DATA_W-1:0] r1_a,
  input  logic [DATA_W-1:0] r1_b,
  input  logic [2:0]        r1_op,
  output logic              r1_gnt,
  output logic              r1_rvalid,
  output logic [DATA_W-1:0] r1_result,
  output logic              r1_zero,
  output logic              r1_err
);

  state_t            state;
  state_t            state_nxt;
  logic              rr_ptr;
  logic              acc;

  logic [DATA_W-1:0] a_p0;
  logic [DATA_W-1:0] b_p0;
  logic [2:0]        op_p0;
  logic              id_p0;

  logic [DATA_W-1:0] alu_y;
  logic              alu_zero;
  logic              legal;
  logic [DATA_W-1:0] res_c;
  logic              zero_c;

  // ---------------------------------------------------------------------------
  // FSM: state register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  // FSM: next state
  always_comb begin
    state_nxt = IDLE;
    case (state)
      IDLE:    state_nxt = acc ? EXEC : IDLE;
      EXEC:    state_nxt = DONE;
      DONE:    state_nxt = acc ? EXEC : IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // FSM: outputs (grant). rr_ptr only breaks ties; a lone requester always
  // wins. Grants are held off during reset and while the ALU is busy (EXEC).
  always_comb begin
    r0_gnt = 1'b0;
    r1_gnt = 1'b0;
    if (!reset && (state == IDLE || state == DONE)) begin
      if (r0_req && (!r1_req || !rr_ptr)) r0_gnt = 1'b1;
      else if (r1_req)                    r1_gnt = 1'b1;
    end
  end

  assign acc = r0_gnt | r1_gnt;

  always_ff @(posedge clk) begin
    if (reset)       rr_ptr <= (PRIO_INIT != 0);
    else if (r0_gnt) rr_ptr <= 1'b1;
    else if (r1_gnt) rr_ptr <= 1'b0;
  end

  // ---------------------------------------------------------------------------
  // Stage p0: operands latched at acceptance
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (acc) begin
      a_p0  <= r1_gnt ? r1_a  : r0_a;
      b_p0  <= r1_gnt ? r1_b  : r0_b;
      op_p0 <= r1_gnt ? r1_op : r0_op;
      id_p0 <= r1_gnt;
    end
  end

  alu32 u_alu (
    .a    (a_p0),
    .b    (b_p0),
    .f    (op_p0),
    .y    (alu_y),
    .zero (alu_zero)
  );

  // Illegal ops discard the ALU output and report a forced zero result.
  assign legal  = is_legal_op(op_p0);
  assign res_c  = legal ? alu_y : '0;
  assign zero_c = legal ? alu_zero : 1'b1;

  // ---------------------------------------------------------------------------
  // Stage p1: per-requester response registers, written at the end of EXEC
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      r0_rvalid <= 1'b0;
      r0_result <= '0;
      r0_zero   <= 1'b0;
      r0_err    <= 1'b0;
      r1_rvalid <= 1'b0;
      r1_result <= '0;
      r1_zero   <= 1'b0;
      r1_err    <= 1'b0;
    end else begin
      r0_rvalid <= 1'b0;
      r1_rvalid <= 1'b0;
      if (state == EXEC) begin
        if (id_p0) begin
          r1_rvalid <= 1'b1;
          r1_result <= res_c;
          r1_zero   <= zero_c;
          r1_err    <= ~legal;
        end else begin
          r0_rvalid <= 1'b1;
          r0_result <= res_c;
          r0_zero   <= zero_c;
          r0_err    <= ~legal;
        end
      end
    end
  end

endmodule

// File: tb/tb_alu_arbiter.sv
// Self-checking bench for alu_arbiter: directed scenarios with literal
// expectations plus a cycle-level reference model checked every cycle.
module tb_alu_arbiter;
  import alu_arbiter_pkg::*;

  localparam int PRIO_INIT = 0;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        r0_req = 1'b0, r1_req = 1'b0;
  logic [31:0] r0_a = '0, r0_b = '0, r1_a = '0, r1_b = '0;
  logic [2:0]  r0_op = '0, r1_op = '0;
  logic        r0_gnt, r0_rvalid, r0_zero, r0_err;
  logic        r1_gnt, r1_rvalid, r1_zero, r1_err;
  logic [31:0] r0_result, r1_result;

  alu_arbiter #(.DATA_W(32), .PRIO_INIT(PRIO_INIT)) dut (
    .clk(clk), .reset(reset),
    .r0_req(r0_req), .r0_a(r0_a), .r0_b(r0_b), .r0_op(r0_op),
    .r0_gnt(r0_gnt), .r0_rvalid(r0_rvalid), .r0_result(r0_result),
    .r0_zero(r0_zero), .r0_err(r0_err),
    .r1_req(r1_req), .r1_a(r1_a), .r1_b(r1_b), .r1_op(r1_op),
    .r1_gnt(r1_gnt), .r1_rvalid(r1_rvalid), .r1_result(r1_result),
    .r1_zero(r1_zero), .r1_err(r1_err)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;
  int cyc = 0;
  bit chk_en = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h (cycle %0d)", name, got, exp, cyc);
    end
  endtask

  // ---------------- reference model ----------------
  typedef struct packed {
    logic [31:0] res;
    logic        z;
    logic        e;
  } mres_t;

  typedef struct {
    int    due;
    bit    id;
    mres_t r;
  } pend_t;

  function automatic mres_t mdl_alu(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    mres_t m;
    m.e = 1'b0;
    case (op)
      3'b010:  m.res = a + b;
      3'b110:  m.res = a - b;
      3'b111:  m.res = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      3'b000:  m.res = a & b;
      3'b001:  m.res = a | b;
      3'b101:  m.res = (b >= 32) ? 32'd0 : (a << b);
      default: begin m.res = 32'd0; m.e = 1'b1; end
    endcase
    m.z = (m.res == 32'd0);
    return m;
  endfunction

  pend_t q[$];
  mres_t h[2];
  bit    m_rr = (PRIO_INIT != 0);
  bit    m_busy = 1'b0;   // an op was accepted last cycle, so no grant now
  bit    eg0, eg1, ev0, ev1;
  pend_t p;

  initial begin
    h[0] = '0;
    h[1] = '0;
  end

  always @(negedge clk) begin
    if (chk_en) begin
      eg0 = 1'b0;
      eg1 = 1'b0;
      if (!reset && !m_busy) begin
        if (r0_req && r1_req) begin
          if (m_rr) eg1 = 1'b1; else eg0 = 1'b1;
        end else if (r0_req) eg0 = 1'b1;
        else if (r1_req)     eg1 = 1'b1;
      end
      check("m_gnt0", r0_gnt, eg0);
      check("m_gnt1", r1_gnt, eg1);
      check("m_gnt_excl", r0_gnt & r1_gnt, 0);

      ev0 = 1'b0;
      ev1 = 1'b0;
      if (q.size() > 0 && q[0].due == cyc) begin
        if (q[0].id) begin ev1 = 1'b1; h[1] = q[0].r; end
        else         begin ev0 = 1'b1; h[0] = q[0].r; end
        void'(q.pop_front());
      end
      check("m_rvalid0", r0_rvalid, ev0);
      check("m_rvalid1", r1_rvalid, ev1);
      check("m_result0", r0_result, h[0].res);
      check("m_zero0", r0_zero, h[0].z);
      check("m_err0", r0_err, h[0].e);
      check("m_result1", r1_result, h[1].res);
      check("m_zero1", r1_zero, h[1].z);
      check("m_err1", r1_err, h[1].e);

      if (reset) begin
        q.delete();
        m_rr = (PRIO_INIT != 0);
        m_busy = 1'b0;
        h[0] = '0;
        h[1] = '0;
      end else begin
        m_busy = eg0 | eg1;
        if (eg0) begin
          p.due = cyc + 2; p.id = 1'b0; p.r = mdl_alu(r0_op, r0_a, r0_b);
          q.push_back(p);
          m_rr = 1'b1;
        end
        if (eg1) begin
          p.due = cyc + 2; p.id = 1'b1; p.r = mdl_alu(r1_op, r1_a, r1_b);
          q.push_back(p);
          m_rr = 1'b0;
        end
      end
    end
  end

  // ---------------- directed stimulus ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic neg();
    @(negedge clk);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

  mres_t pr;

  initial begin
    // Pin the model against hand-computed values.
    pr = mdl_alu(3'b101, 32'd1, 32'd31);
    check("mdl_sll31", pr.res, 32'h8000_0000);
    pr = mdl_alu(3'b101, 32'd1, 32'd32);
    check("mdl_sll32_zero", pr.z, 1);
    pr = mdl_alu(3'b111, 32'hFFFF_FFFF, 32'd1);
    check("mdl_slt_neg", pr.res, 1);
    pr = mdl_alu(3'b100, 32'd5, 32'd5);
    check("mdl_illegal", {pr.z, pr.e}, 2'b11);

    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    chk_en = 1'b1;

    // Test 1: single add
    r0_req = 1'b1; r0_a = 32'd5; r0_b = 32'd7; r0_op = 3'b010;
    neg(); check("t1_gnt", r0_gnt, 1);
    step(); r0_req = 1'b0;
    step(); neg();
    check("t1_rvalid", r0_rvalid, 1);
    check("t1_result", r0_result, 12);
    check("t1_zero", r0_zero, 0);
    check("t1_err", r0_err, 0);
    check("t1_r1v", r1_rvalid, 0);

    // Test 2: both requesting continuously, from a fresh reset
    step(); reset = 1'b1;
    step(); reset = 1'b0;
    r0_req = 1'b1; r0_a = 32'd9; r0_b = 32'd9; r0_op = 3'b110;
    r1_req = 1'b1; r1_a = 32'd3; r1_b = 32'd4; r1_op = 3'b111;
    for (int k = 0; k < 7; k++) begin
      if (k > 0) step();
      neg();
      if (k % 2 == 0) begin
        check("t2_gnt0", r0_gnt, (k % 4 == 0));
        check("t2_gnt1", r1_gnt, (k % 4 == 2));
      end
      if (k == 2) begin
        check("t2_r0v", r0_rvalid, 1);
        check("t2_r0res", r0_result, 0);
        check("t2_r0zero", r0_zero, 1);
      end
      if (k == 4) begin
        check("t2_r1v", r1_rvalid, 1);
        check("t2_r1res", r1_result, 1);
        check("t2_r1zero", r1_zero, 0);
      end
    end
    step(); r0_req = 1'b0; r1_req = 1'b0;
    step();

    // Test 3: back-to-back shifts from DONE
    step(); r1_req = 1'b1; r1_a = 32'd1; r1_b = 32'd31; r1_op = 3'b101;
    neg(); check("t3_gnt_a", r1_gnt, 1);
    step(); r1_req = 1'b0;
    step(); r1_req = 1'b1; r1_b = 32'd32;
    neg();
    check("t3_gnt_b", r1_gnt, 1);
    check("t3_rv_a", r1_rvalid, 1);
    check("t3_res_a", r1_result, 32'h8000_0000);
    check("t3_zero_a", r1_zero, 0);
    step(); r1_req = 1'b0;
    neg(); check("t3_gap", r1_rvalid, 0);
    step(); neg();
    check("t3_rv_b", r1_rvalid, 1);
    check("t3_res_b", r1_result, 0);
    check("t3_zero_b", r1_zero, 1);

    // Test 4: illegal op, then a legal signed slt
    step(); r0_req = 1'b1; r0_a = 32'h0000_FFFF; r0_b = 32'd1; r0_op = 3'b011;
    neg(); check("t4_gnt", r0_gnt, 1);
    step(); r0_req = 1'b0;
    step(); r0_req = 1'b1; r0_a = 32'hFFFF_FFFF; r0_b = 32'd1; r0_op = 3'b111;
    neg();
    check("t4_rv", r0_rvalid, 1);
    check("t4_res", r0_result, 0);
    check("t4_zero", r0_zero, 1);
    check("t4_err", r0_err, 1);
    check("t4_gnt2", r0_gnt, 1);
    step(); r0_req = 1'b0;
    step(); neg();
    check("t4_rv2", r0_rvalid, 1);
    check("t4_res2", r0_result, 1);
    check("t4_err2", r0_err, 0);

    // Test 5: reset while an op is in EXEC
    step(); r0_req = 1'b1; r0_a = 32'hF0; r0_b = 32'hFF; r0_op = 3'b000;
    neg(); check("t5_gnt", r0_gnt, 1);
    step(); r0_req = 1'b0; reset = 1'b1;
    step(); reset = 1'b0;
    r0_req = 1'b1; r0_a = 32'd2; r0_b = 32'd3; r0_op = 3'b010;
    r1_req = 1'b1; r1_a = 32'd4; r1_b = 32'd1; r1_op = 3'b001;
    neg();
    check("t5_norv", r0_rvalid, 0);
    check("t5_res0", r0_result, 0);
    check("t5_zero0", r0_zero, 0);
    check("t5_err0", r0_err, 0);
    check("t5_tie0", r0_gnt, 1);
    check("t5_tie1", r1_gnt, 0);
    step(); r0_req = 1'b0; r1_req = 1'b0;
    step(); neg();
    check("t5_rv", r0_rvalid, 1);
    check("t5_resb", r0_result, 5);

    // Test 6: r1 request withdrawn while the ALU is busy
    step(); r0_req = 1'b1; r0_a = 32'd10; r0_b = 32'd20; r0_op = 3'b010;
    neg(); check("t6_gnt0", r0_gnt, 1);
    step(); r0_req = 1'b0; r1_req = 1'b1; r1_a = 32'd7; r1_b = 32'd2; r1_op = 3'b110;
    neg(); check("t6_nogntx", r1_gnt, 0);
    step(); r1_req = 1'b0;
    neg();
    check("t6_nognt", r1_gnt, 0);
    check("t6_nor1v", r1_rvalid, 0);
    check("t6_r0res", r0_result, 30);
    step(); r0_req = 1'b1; r1_req = 1'b1;
    neg();
    check("t6_tie1", r1_gnt, 1);
    check("t6_tie0", r0_gnt, 0);
    step(); r0_req = 1'b0; r1_req = 1'b0;
    repeat (3) step();
    neg();
    #1;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/alu_arbiter.md
Name: alu_arbiter

Overview:
- Shares one alu32 instance between two requesters, e.g. the main execute path (requester 0) and a branch/address helper (requester 1).
- Arbitration is round-robin with a req/gnt handshake.
- Operands and opcode are registered, and each requester gets back a registered result, zero flag and error flag.
- The block sits between the requesters and the single ALU, so the ALU can be time-multiplexed instead of duplicated.

Parameters:
- DATA_W, 32: operand/result width. Fixed at 32 to match alu32; any other value is unsupported.
- PRIO_INIT, 0: requester that wins the first tie after reset (0 or 1).

Ports:
- clk  input  1  clock; all state changes on rising edge.
- reset  input  1  synchronous, active-high reset.
- r0_req  input  1  requester 0 has an operation pending.
- r0_a  input  32  requester 0 operand a.
- r0_b  input  32  requester 0 operand b.
- r0_op  input  3  requester 0 ALU control code.
- r0_gnt  output  1  combinational; request 0 accepted this cycle.
- r0_rvalid  output  1  one-cycle pulse; r0_result/r0_zero/r0_err valid.
- r0_result  output  32  registered result for requester 0.
- r0_zero  output  1  registered zero flag (result == 0).
- r0_err  output  1  registered; op code was illegal.
- r1_req, r1_a, r1_b, r1_op, r1_gnt, r1_rvalid, r1_result, r1_zero, r1_err: same as requester 0, for requester 1.

Behaviour:
- Clock and reset: one clock; reset is synchronous and active-high; ports are named clk and reset.
- Legal op codes: 010 add, 110 sub, 111 slt, 000 and, 001 or, 101 shift-left a by b.
- Shift amount: the full 32-bit b is used; b >= 32 gives result 0.
- Illegal op codes (011, 100):
  - the ALU output is ignored;
  - result = 0, zero = 1, err = 1;
  - handshake and timing are identical to a legal op.
- FSM states: IDLE, EXEC, DONE.
- Grant window: gnt may assert only in IDLE or DONE.
- Arbitration:
  - only one requester has req → grant it;
  - both have req → grant the requester selected by rr_ptr;
  - after a grant to requester i, rr_ptr = 1 - i;
  - rr_ptr resets to PRIO_INIT.
- Acceptance: an op is accepted in cycle N when req and gnt are both high. At that edge:
  - a, b, op and the requester id are latched;
  - state goes to EXEC.
- EXEC (cycle N+1):
  - alu32 is fed from the latched registers only;
  - sum, zout and illegal-op status are registered at the end of the cycle;
  - state goes to DONE.
- DONE (cycle N+2):
  - rvalid pulses for exactly one cycle, only for the owning requester;
  - the other requester's rvalid stays 0;
  - if a new request is granted in the same cycle, state goes to EXEC; otherwise IDLE.
- Latency and throughput: accept at N → rvalid at N+2. Sustained throughput is 1 op per 2 cycles.
- Holding outputs:
  - result/zero/err hold their last values until the next rvalid for that requester;
  - they are only meaningful while rvalid is high.
- Requester rules:
  - a requester keeps op/a/b stable while req is high and gnt is low;
  - dropping req before grant is legal and produces no response.
- Reset values: gnt = 0, rvalid = 0, result = 0, zero = 0, err = 0, state = IDLE, rr_ptr = PRIO_INIT.
- Reset mid-operation: the in-flight op is aborted and no rvalid is ever issued for it.
- gnt is never asserted in EXEC, even if req is high.
- The gnt outputs are mutually exclusive in every cycle.

Decomposition:
- Shared package holds:
  - ALU op constants ALU_ADD = 3'b010, ALU_SUB = 3'b110, ALU_SLT = 3'b111, ALU_AND = 3'b000, ALU_OR = 3'b001, ALU_SLL = 3'b101;
  - FSM state encoding (IDLE/EXEC/DONE);
  - an is_legal_op function.
- Sub-module: one instance of the existing alu32, fed only from the latched operand registers.
- Arbitration, FSM and response registers live in alu_arbiter itself.

Test Plan:
1. Single op, add: r0_req, a = 5, b = 7, op = 010 at cycle 1 → r0_gnt = 1 at cycle 1; r0_rvalid = 1 at cycle 3 with result = 12, zero = 0, err = 0; r1_rvalid stays 0.
2. Both requesting, PRIO_INIT = 0:
   - r0 sub 9 - 9 and r1 slt 3 < 4, held high continuously;
   - expected grant order r0, r1, r0, r1;
   - r0 gets result 0, zero = 1;
   - r1 gets result 1, zero = 0.
3. Back-to-back from DONE:
   - r1 issues shift a = 1, b = 31 then shift a = 1, b = 32;
   - second gnt coincides with the first rvalid;
   - results 0x80000000 then 0 (zero = 1);
   - rvalid pulses 2 cycles apart.
4. Illegal op: r0 op = 011, a = 0xFFFF, b = 1 → rvalid at N+2 with result = 0, zero = 1, err = 1; the next legal op reports err = 0.
5. Reset mid-op: r0 and-op accepted at N, reset high at N+1 → no rvalid at N+2; all outputs 0; after reset a tie is granted to PRIO_INIT.
6. Withdrawn request: r1_req pulsed only during EXEC, then dropped → no r1_gnt and no r1_rvalid; rr_ptr unchanged.
